// File: rtl/mem_mp_model_pkg.sv
// Shared defaults and helpers for the multi-port memory model.
package mem_mp_model_pkg;

  localparam int MEM_NUM_PORTS = 2;
  localparam int MEM_WORDS_DEF = 2048;
  localparam int MEM_LATENCY   = 2;

  // Width of an index over n items, never below one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_mp_model_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last winner.
module rr_arbiter
  import mem_mp_model_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = clog2_min1(N)
) (
  input  logic          clk_mem,
  input  logic          rst_n,
  input  logic [N-1:0]  req_vec,
  input  logic          grant_en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] nxt;
  logic          found;

  // first requester after ptr, wrapping around
  always_comb begin
    logic [PW-1:0] ci;
    grant = '0;
    found = 1'b0;
    nxt   = ptr;
    ci    = '0;
    for (int k = 1; k <= N; k++) begin
      ci = PW'((int'(ptr) + k) % N);
      if (!found && grant_en && req_vec[ci]) begin
        grant[ci] = 1'b1;
        found     = 1'b1;
        nxt       = ci;
      end
    end
  end

  // pointer starts at the last port so port 0 wins first; moves on grant only
  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n)     ptr <= PW'(N - 1);
    else if (found) ptr <= nxt;
  end

endmodule

// File: rtl/mem_mp_model.sv
// Multi-port word memory: edge-triggered requests, round-robin access,
// byte-strobe writes, fixed response latency, out-of-range error.
module mem_mp_model
  import mem_mp_model_pkg::*;
#(
  parameter int    NUM_PORTS = MEM_NUM_PORTS,
  parameter int    ADDR_W    = 32,
  parameter int    DATA_W    = 32,
  parameter int    MEM_WORDS = MEM_WORDS_DEF,
  parameter int    LATENCY   = MEM_LATENCY,
  parameter string INIT_FILE = ""
) (
  input  logic                                  clk_mem,
  input  logic                                  rst_n,
  input  logic [NUM_PORTS-1:0]                  req,
  input  logic [NUM_PORTS-1:0]                  we,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]      addr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]      wdata,
  input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]    wstrb,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]      rdata,
  output logic [NUM_PORTS-1:0]                  res,
  output logic [NUM_PORTS-1:0]                  err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = ADDR_W - 2;
  localparam int MA_W   = clog2_min1(MEM_WORDS);
  localparam int PW     = clog2_min1(NUM_PORTS);

  typedef struct packed {
    logic              we;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              pending;
  } mem_slot_t;

  typedef struct packed {
    logic              valid;
    logic [PW-1:0]     port;
    logic [DATA_W-1:0] data;
    logic              err;
  } mem_rsp_t;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  mem_slot_t                  slot [NUM_PORTS];
  logic [NUM_PORTS-1:0]       req_d, start, pend_vec, gnt;
  logic [NUM_PORTS-1:0][1:0]  addr_lo_unused;
  logic [PW-1:0]              arb_ptr_unused;
  logic [PW-1:0]              gport;
  logic                       gnt_any, g_we, in_range;
  logic [IDX_W-1:0]           g_idx;
  logic [DATA_W-1:0]          g_wdata, old_word, merged;
  logic [STRB_W-1:0]          g_wstrb;
  logic [MA_W-1:0]            widx;
  mem_rsp_t                   rsp0, tail_in;

  assign start = req & ~req_d;

  // word addressing drops the byte offset
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) addr_lo_unused[p] = addr[p][1:0];
  end

  // per-port request slots: capture on a rising req, clear on grant
  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      req_d <= '0;
      for (int p = 0; p < NUM_PORTS; p++) slot[p] <= '0;
    end else begin
      req_d <= req;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (gnt[p])
          slot[p].pending <= 1'b0;
        else if (start[p] && !slot[p].pending)
          slot[p] <= '{we: we[p], idx: addr[p][ADDR_W-1:2], wdata: wdata[p],
                       wstrb: wstrb[p], pending: 1'b1};
      end
    end
  end

  // pending flags feed the arbiter
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) pend_vec[p] = slot[p].pending;
  end

  rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_arb (
    .clk_mem  (clk_mem),
    .rst_n    (rst_n),
    .req_vec  (pend_vec),
    .grant_en (1'b1),
    .grant    (gnt),
    .ptr      (arb_ptr_unused)
  );

  // select the granted slot and form the access result
  always_comb begin
    gport   = '0;
    g_we    = 1'b0;
    g_idx   = '0;
    g_wdata = '0;
    g_wstrb = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p]) begin
        gport   = PW'(p);
        g_we    = slot[p].we;
        g_idx   = slot[p].idx;
        g_wdata = slot[p].wdata;
        g_wstrb = slot[p].wstrb;
      end
    end
    gnt_any  = |gnt;
    in_range = (g_idx < IDX_W'(MEM_WORDS));
    widx     = g_idx[MA_W-1:0];
    old_word = in_range ? mem[widx] : '0;
    for (int b = 0; b < STRB_W; b++)
      merged[b*8 +: 8] = g_wstrb[b] ? g_wdata[b*8 +: 8] : old_word[b*8 +: 8];
    rsp0.valid = gnt_any;
    rsp0.port  = gport;
    rsp0.data  = !in_range ? '0 : (g_we ? merged : old_word);
    rsp0.err   = gnt_any & ~in_range;
  end

  // array write at the end of the grant cycle; contents survive reset
  always_ff @(posedge clk_mem) begin
    if (gnt_any && g_we && in_range) mem[widx] <= merged;
  end

  if (LATENCY == 1) begin : g_nopipe
    assign tail_in = rsp0;
  end else begin : g_pipe
    mem_rsp_t pipe [1:LATENCY-1];
    // delay line between the array access and the output registers
    always_ff @(posedge clk_mem or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 1; i < LATENCY; i++) pipe[i] <= '0;
      end else begin
        pipe[1] <= rsp0;
        for (int i = 2; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign tail_in = pipe[LATENCY-1];
  end

  // registered outputs: one-cycle res/err pulse, rdata held until next res
  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      res   <= '0;
      err   <= '0;
      rdata <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        res[p] <= tail_in.valid && (tail_in.port == PW'(p));
        err[p] <= tail_in.valid && (tail_in.port == PW'(p)) && tail_in.err;
        if (tail_in.valid && (tail_in.port == PW'(p))) rdata[p] <= tail_in.data;
      end
    end
  end

endmodule

// File: tb/tb_mem_mp_model.sv
// Bench for mem_mp_model: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_mem_mp_model;

  localparam int NP  = 3;
  localparam int LAT = 2;
  localparam int MW  = 2048;

  logic                 clk_mem = 1'b0;
  logic                 rst_n;
  logic [NP-1:0]        req, we, res, err;
  logic [NP-1:0][31:0]  addr, wdata, rdata;
  logic [NP-1:0][3:0]   wstrb;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mem_mp_model #(
    .NUM_PORTS(NP), .ADDR_W(32), .DATA_W(32), .MEM_WORDS(MW),
    .LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk_mem(clk_mem), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .res(res), .err(err)
  );

  always #5 clk_mem = ~clk_mem;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int port; logic [31:0] data; bit err; } exp_t;
  exp_t        rq[$];
  logic [31:0] mmem [MW];
  bit          m_pend [NP];
  bit          m_we   [NP];
  logic [29:0] m_idx  [NP];
  logic [31:0] m_wd   [NP];
  logic [3:0]  m_st   [NP];
  logic [NP-1:0] m_req_prev = '0;
  int          m_last = NP - 1;
  int          edge_n = 0;
  logic [NP-1:0] exp_res = '0, exp_err = '0;
  logic [31:0] exp_rd [NP] = '{default: 32'h0};

  always @(posedge clk_mem or negedge rst_n) begin : model
    int g;
    bit pend_b [NP];
    bit inr;
    logic [31:0] old, nw;
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin m_pend[p] = 0; exp_rd[p] = '0; end
      rq.delete();
      m_last = NP - 1;
      m_req_prev = '0;
      exp_res = '0;
      exp_err = '0;
    end else begin
      edge_n++;
      for (int p = 0; p < NP; p++) pend_b[p] = m_pend[p];
      g = -1;
      for (int k = 1; k <= NP; k++)
        if (g < 0 && m_pend[(m_last + k) % NP]) g = (m_last + k) % NP;
      if (g >= 0) begin
        inr = (m_idx[g] < MW);
        old = inr ? mmem[int'(m_idx[g])] : 32'h0;
        nw  = old;
        for (int b = 0; b < 4; b++) if (m_st[g][b]) nw[8*b +: 8] = m_wd[g][8*b +: 8];
        if (!inr) rq.push_back('{edge_n + LAT - 1, g, 32'h0, 1'b1});
        else begin
          if (m_we[g]) mmem[int'(m_idx[g])] = nw;
          rq.push_back('{edge_n + LAT - 1, g, m_we[g] ? nw : old, 1'b0});
        end
        m_pend[g] = 0;
        m_last = g;
      end
      for (int p = 0; p < NP; p++)
        if (req[p] && !m_req_prev[p] && !pend_b[p]) begin
          m_we[p] = we[p]; m_idx[p] = addr[p][31:2];
          m_wd[p] = wdata[p]; m_st[p] = wstrb[p]; m_pend[p] = 1;
        end
      m_req_prev = req;
      exp_res = '0;
      exp_err = '0;
      while (rq.size() > 0 && rq[0].due == edge_n) begin
        exp_res[rq[0].port] = 1'b1;
        exp_err[rq[0].port] = rq[0].err;
        exp_rd[rq[0].port]  = rq[0].data;
        void'(rq.pop_front());
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk_mem) begin
    if (chk_en) begin
      for (int p = 0; p < NP; p++) begin
        check($sformatf("res[%0d] edge %0d", p, edge_n), 32'(res[p]), 32'(exp_res[p]));
        check($sformatf("err[%0d] edge %0d", p, edge_n), 32'(err[p]), 32'(exp_err[p]));
        check($sformatf("rdata[%0d] edge %0d", p, edge_n), rdata[p], exp_rd[p]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_access(input int p, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rd, output bit e, output int lat);
    @(posedge clk_mem); #1;
    we[p] = w; addr[p] = a; wdata[p] = d; wstrb[p] = s; req[p] = 1'b1;
    lat = 0; rd = '0; e = 1'b0;
    while (lat < 100) begin
      @(posedge clk_mem); lat++; #1;
      if (res[p]) begin rd = rdata[p]; e = err[p]; break; end
    end
    if (lat >= 100) begin
      checks++; errors++;
      $display("FAIL timeout port %0d: no res within 100 cycles, expected one", p);
    end
    req[p] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk_mem); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk_mem);
    #1 rst_n = 1'b1;
  endtask

  task automatic rand_driver(input int p, input int n);
    logic [31:0] a, d, rd;
    logic [3:0]  s;
    bit          w, e;
    int          lat;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk_mem);
      if ($urandom_range(0, 9) < 8)
        a = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      else
        a = $urandom | 32'h0000_2000;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      do_access(p, w, a, d, s, rd, e, lat);
    end
  endtask

  logic [31:0] init_w [16];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    bit          e;
    int          lat, l0, l1, l2, c2, cany;

    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; wstrb = '0;
    @(posedge clk_mem);
    chk_en = 1'b1;
    repeat (2) @(posedge clk_mem);
    #1 rst_n = 1'b1;

    // reset state
    check("reset res", 32'(res), 32'h0);
    check("reset err", 32'(err), 32'h0);
    check("reset rdata0", rdata[0], 32'h0);
    check("reset rdata1", rdata[1], 32'h0);

    // known contents for the words the traffic touches
    for (int i = 0; i < 16; i++) begin
      init_w[i] = $urandom;
      do_access(0, 1'b1, 32'(i * 4), init_w[i], 4'hF, rd, e, lat);
    end

    // full write then read of 0x10
    do_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
    check("wr 0x10 rdata", rd, 32'hDEADBEEF);
    check("wr 0x10 err", 32'(e), 32'h0);
    do_access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check("rd 0x10 latency", 32'(lat), 32'd3);
    check("rd 0x10 rdata", rd, 32'hDEADBEEF);
    check("rd 0x10 err", 32'(e), 32'h0);

    // byte-strobe merge
    do_access(1, 1'b1, 32'h10, 32'h000000AA, 4'h1, rd, e, lat);
    check("strb wr rdata", rd, 32'hDEADBEAA);
    do_access(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check("strb rd rdata", rd, 32'hDEADBEAA);

    // out of range: error, zero data, array untouched
    do_access(0, 1'b0, 32'h2000, 32'h0, 4'h0, rd, e, lat);
    check("oor rd err", 32'(e), 32'h1);
    check("oor rd rdata", rd, 32'h0);
    do_access(0, 1'b1, 32'h2000, 32'h12345678, 4'hF, rd, e, lat);
    check("oor wr err", 32'(e), 32'h1);
    check("oor wr rdata", rd, 32'h0);
    do_access(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, e, lat);
    check("word0 after oor", rd, init_w[0]);

    // simultaneous starts on ports 0,1 with pointer at reset
    pulse_reset();
    @(posedge clk_mem); #1;
    we[0] = 0; addr[0] = 32'h10; we[1] = 0; addr[1] = 32'h14;
    req[0] = 1; req[1] = 1;
    l0 = 0; l1 = 0;
    for (int n = 1; n <= 50 && (l0 == 0 || l1 == 0); n++) begin
      @(posedge clk_mem); #1;
      if (res[0] && l0 == 0) begin l0 = n; req[0] = 0; end
      if (res[1] && l1 == 0) begin l1 = n; req[1] = 0; end
    end
    check("dual port0 res edge", 32'(l0), 32'd3);
    check("dual port1 res edge", 32'(l1), 32'd4);

    // three-way contention; port2 re-raises while pending and holds req past res
    pulse_reset();
    @(posedge clk_mem); #1;
    for (int p = 0; p < NP; p++) begin we[p] = 0; addr[p] = 32'(p * 4); end
    req = '1;
    l0 = 0; l1 = 0; l2 = 0; c2 = 0;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk_mem); #1;
      if (n == 1) req[2] = 1'b0;
      if (n == 2) req[2] = 1'b1;
      if (res[0] && l0 == 0) begin l0 = n; req[0] = 0; end
      if (res[1] && l1 == 0) begin l1 = n; req[1] = 0; end
      if (res[2]) begin c2++; if (l2 == 0) l2 = n; end
    end
    req[2] = 1'b0;
    check("rr port0 res edge", 32'(l0), 32'd3);
    check("rr port1 res edge", 32'(l1), 32'd4);
    check("rr port2 res edge", 32'(l2), 32'd5);
    check("port2 res count", 32'(c2), 32'd1);

    // reset one cycle after grant drops the access
    @(posedge clk_mem); #1;
    we[0] = 0; addr[0] = 32'h10; req[0] = 1;
    repeat (2) @(posedge clk_mem);
    #1 rst_n = 1'b0; req[0] = 1'b0;
    #1;
    check("rst res", 32'(res), 32'h0);
    check("rst err", 32'(err), 32'h0);
    check("rst rdata0", rdata[0], 32'h0);
    repeat (2) @(posedge clk_mem);
    #1 rst_n = 1'b1;
    cany = 0;
    repeat (6) begin @(posedge clk_mem); #1; if (|res) cany++; end
    check("no res after reset", 32'(cany), 32'h0);
    do_access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check("0x10 survives reset", rd, 32'hDEADBEAA);

    // random traffic on all ports
    for (int p = 0; p < NP; p++) begin
      fork
        automatic int q = p;
        rand_driver(q, 25);
      join_none
    end
    wait fork;
    repeat (8) @(posedge clk_mem);
    @(negedge clk_mem);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
